// File: rtl/block_header_generator.sv
// Candidate block header source for the MD5 nonce search: captures the key, then emits
// key || decimal ASCII nonce (1, 2, 3, ...) right-aligned with the units digit in byte 0.
module block_header_generator #(
  parameter int unsigned BLOCK_HEADER_WIDTH = 256,
  parameter int unsigned NONCE_DIGITS       = 8,
  parameter int unsigned KEY_MAX_CHARS      = 16
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        key_valid,
  input  logic [7:0]                                  key_data,
  input  logic                                        key_last,
  input  logic                                        stop,
  input  logic                                        block_header_ready,
  output logic                                        block_header_valid,
  output logic [BLOCK_HEADER_WIDTH-1:0]               block_header_data,
  output logic [$clog2(BLOCK_HEADER_WIDTH/8+1)-1:0]   block_header_length,
  output logic                                        overflow
);

  localparam int unsigned HdrBytes  = BLOCK_HEADER_WIDTH / 8;
  localparam int unsigned LenW      = $clog2(HdrBytes + 1);
  localparam int unsigned KeyW      = KEY_MAX_CHARS * 8;
  localparam int unsigned NonceW    = NONCE_DIGITS * 8;
  localparam int unsigned KeyLenW   = $clog2(KEY_MAX_CHARS + 1);
  localparam int unsigned NonceLenW = $clog2(NONCE_DIGITS + 1);

  if (KEY_MAX_CHARS + NONCE_DIGITS > HdrBytes) begin : g_size_check
    $error("KEY_MAX_CHARS + NONCE_DIGITS exceeds header bytes");
  end

  typedef enum logic [1:0] {StLoadKey, StRun, StDone} state_e;

  state_e                  r_state, w_state_d;
  logic [KeyW-1:0]         r_key, w_key_d;
  logic [KeyLenW-1:0]      r_key_len, w_key_len_d;
  logic [NonceW-1:0]       r_nonce, w_nonce_d, w_nonce_inc;
  logic [NonceLenW-1:0]    r_nonce_len, w_nonce_len_d, w_nonce_len_inc;
  logic                    w_nonce_wrap;
  logic                    r_valid, w_valid_d;
  logic [BLOCK_HEADER_WIDTH-1:0] r_data, w_data_d, w_packed;
  logic [LenW-1:0]         r_length, w_length_d;
  logic                    r_overflow, w_overflow_d;
  logic                    w_fire;

  assign w_fire = r_valid && block_header_ready;

  // ASCII ripple increment; unused upper digit bytes stay 0x00 so packing is a plain OR.
  always_comb begin
    logic carry;
    w_nonce_inc     = r_nonce;
    w_nonce_len_inc = r_nonce_len;
    w_nonce_wrap    = 1'b0;
    carry           = 1'b1;
    for (int i = 0; i < int'(NONCE_DIGITS); i++) begin
      if (carry && (i < int'(r_nonce_len))) begin
        if (r_nonce[i*8 +: 8] == 8'h39) begin
          w_nonce_inc[i*8 +: 8] = 8'h30;
        end else begin
          w_nonce_inc[i*8 +: 8] = r_nonce[i*8 +: 8] + 8'd1;
          carry = 1'b0;
        end
      end
    end
    if (carry) begin
      if (int'(r_nonce_len) == int'(NONCE_DIGITS)) begin
        w_nonce_wrap = 1'b1;
      end else begin
        for (int i = 0; i < int'(NONCE_DIGITS); i++) begin
          if (i == int'(r_nonce_len)) w_nonce_inc[i*8 +: 8] = 8'h31;
        end
        w_nonce_len_inc = r_nonce_len + 1'b1;
      end
    end
  end

  assign w_packed = (BLOCK_HEADER_WIDTH'(r_key) << {w_nonce_len_d, 3'b000})
                  | BLOCK_HEADER_WIDTH'(w_nonce_d);

  always_comb begin
    w_state_d     = r_state;
    w_key_d       = r_key;
    w_key_len_d   = r_key_len;
    w_nonce_d     = r_nonce;
    w_nonce_len_d = r_nonce_len;
    w_valid_d     = 1'b0;
    w_data_d      = r_data;
    w_length_d    = r_length;
    w_overflow_d  = r_overflow;
    case (r_state)
      StLoadKey: begin
        if (key_valid) begin
          if (r_key_len < KeyLenW'(KEY_MAX_CHARS)) begin
            w_key_d     = (r_key << 8) | KeyW'(key_data);
            w_key_len_d = r_key_len + 1'b1;
          end
          if (key_last) begin
            w_state_d     = StRun;
            w_nonce_d     = NonceW'(8'h31);
            w_nonce_len_d = NonceLenW'(1);
          end
        end
      end
      StRun: begin
        if (w_fire) begin
          if (w_nonce_wrap) begin
            w_overflow_d = 1'b1;
            w_state_d    = StDone;
          end else begin
            w_nonce_d     = w_nonce_inc;
            w_nonce_len_d = w_nonce_len_inc;
          end
        end
        if (stop) w_state_d = StDone;
        w_valid_d  = (w_state_d == StRun);
        w_data_d   = w_packed;
        w_length_d = LenW'(r_key_len) + LenW'(w_nonce_len_d);
      end
      StDone: begin
        w_state_d = StDone;
      end
      default: begin
        w_state_d = StLoadKey;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StLoadKey;
      r_key       <= '0;
      r_key_len   <= '0;
      r_nonce     <= '0;
      r_nonce_len <= '0;
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_length    <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_key       <= w_key_d;
      r_key_len   <= w_key_len_d;
      r_nonce     <= w_nonce_d;
      r_nonce_len <= w_nonce_len_d;
      r_valid     <= w_valid_d;
      r_data      <= w_data_d;
      r_length    <= w_length_d;
      r_overflow  <= w_overflow_d;
    end
  end

  assign block_header_valid  = r_valid;
  assign block_header_data   = r_data;
  assign block_header_length = r_length;
  assign overflow            = r_overflow;

endmodule

// File: tb/tb_block_header_generator.sv
// Bench for block_header_generator: string-based header model, scoreboarded streams,
// a digit-growth vector table and hand sequences for stop, overflow and mid-run reset.
module tb_block_header_generator;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         key_valid = 1'b0;
  logic [7:0]   key_data = 8'h00;
  logic         key_last = 1'b0;
  logic         stop = 1'b0;
  logic         ready = 1'b0;

  logic         a_valid, b_valid, a_ovf, b_ovf;
  logic [255:0] a_data, b_data;
  logic [5:0]   a_len, b_len;

  logic         cur_valid, cur_ovf;
  logic [255:0] cur_data;
  logic [5:0]   cur_len;
  bit           sel_b = 1'b0;

  always #5 clk = ~clk;

  block_header_generator #(
    .BLOCK_HEADER_WIDTH(256), .NONCE_DIGITS(8), .KEY_MAX_CHARS(16)
  ) u_dut_a (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_data(key_data),
    .key_last(key_last), .stop(stop), .block_header_ready(ready),
    .block_header_valid(a_valid), .block_header_data(a_data),
    .block_header_length(a_len), .overflow(a_ovf)
  );

  block_header_generator #(
    .BLOCK_HEADER_WIDTH(256), .NONCE_DIGITS(2), .KEY_MAX_CHARS(16)
  ) u_dut_b (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_data(key_data),
    .key_last(key_last), .stop(stop), .block_header_ready(ready),
    .block_header_valid(b_valid), .block_header_data(b_data),
    .block_header_length(b_len), .overflow(b_ovf)
  );

  assign cur_valid = sel_b ? b_valid : a_valid;
  assign cur_data  = sel_b ? b_data  : a_data;
  assign cur_len   = sel_b ? b_len   : a_len;
  assign cur_ovf   = sel_b ? b_ovf   : a_ovf;

  int           checks = 0;
  int           errors = 0;
  int           exp_n = 1;
  bit           prev_valid, prev_ready;
  logic [255:0] prev_data;
  logic [255:0] seen_data [0:127];
  int           seen_len  [0:127];

  typedef struct {
    int         n;
    logic [7:0] b0;
    logic [7:0] b1;
    int         len;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic string model_str(input string key, input int n);
    string k;
    k = (key.len() > 16) ? key.substr(0, 15) : key;
    return {k, $sformatf("%0d", n)};
  endfunction

  function automatic logic [255:0] model_hdr(input string s);
    logic [255:0] h;
    h = '0;
    for (int i = 0; i < s.len(); i++) h[i*8 +: 8] = s[s.len()-1-i];
    return h;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; key_valid = 1'b0; key_last = 1'b0; stop = 1'b0; ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", a_valid, 1'b0);
    chk("rst_data", a_data, 256'd0);
    chk("rst_len", a_len, 6'd0);
    chk("rst_ovf", a_ovf, 1'b0);
    chk("rst_b_valid", b_valid, 1'b0);
    chk("rst_b_ovf", b_ovf, 1'b0);
    reset = 1'b0;
  endtask

  task automatic load_key(input string k);
    for (int i = 0; i < k.len(); i++) begin
      @(negedge clk);
      key_valid = 1'b1;
      key_data  = k[i];
      key_last  = (i == k.len() - 1);
    end
    @(negedge clk);
    key_valid = 1'b0;
    key_last  = 1'b0;
    chk("valid_low_one_cycle", cur_valid, 1'b0);
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    exp_n = 1;
  endtask

  // One cycle of scoreboarded streaming; stop is raised together with the fire of stop_n.
  task automatic step(input string key, input bit rnd, input int stop_n);
    string s;
    @(negedge clk);
    if (cur_valid) begin
      s = model_str(key, exp_n);
      chk($sformatf("hdr_data_n%0d", exp_n), cur_data, model_hdr(s));
      chk($sformatf("hdr_len_n%0d", exp_n), cur_len, s.len());
      chk("ovf_low_while_valid", cur_ovf, 1'b0);
      if (!sel_b && exp_n < 128) begin
        seen_data[exp_n] = cur_data;
        seen_len[exp_n]  = cur_len;
      end
    end
    if (prev_valid && !prev_ready) begin
      chk("bp_valid_hold", cur_valid, 1'b1);
      chk("bp_data_hold", cur_data, prev_data);
    end
    ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    if (rnd) begin
      key_valid = 1'($urandom_range(0, 1));
      key_data  = 8'h7a;
      key_last  = key_valid;
    end
    stop = (stop_n != 0) && cur_valid && (exp_n == stop_n);
    prev_valid = cur_valid;
    prev_ready = ready;
    prev_data  = cur_data;
    if (cur_valid && ready) exp_n++;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      seen_data[i] = '0;
      seen_len[i]  = 0;
    end
    tbl[0] = '{1,   8'h31, 8'h66, 7};
    tbl[1] = '{9,   8'h39, 8'h66, 7};
    tbl[2] = '{10,  8'h30, 8'h31, 8};
    tbl[3] = '{11,  8'h31, 8'h31, 8};
    tbl[4] = '{100, 8'h30, 8'h30, 9};

    // First header and digit growth
    do_reset();
    load_key("abcdef");
    step("abcdef", 1'b0, 0);
    chk("start_latency_valid", prev_valid, 1'b1);
    chk("first_byte6_a", seen_data[1][55:48], 8'h61);
    chk("first_byte7_zero", seen_data[1][63:56], 8'h00);
    for (int c = 0; c < 200 && exp_n < 101; c++) step("abcdef", 1'b0, 0);
    chk("growth_reach", exp_n, 101);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("tbl_b0_n%0d", tbl[i].n), seen_data[tbl[i].n][7:0], tbl[i].b0);
      chk($sformatf("tbl_b1_n%0d", tbl[i].n), seen_data[tbl[i].n][15:8], tbl[i].b1);
      chk($sformatf("tbl_len_n%0d", tbl[i].n), seen_len[tbl[i].n], tbl[i].len);
    end

    // Random backpressure with key noise during RUN
    do_reset();
    load_key("abcdef");
    for (int c = 0; c < 300; c++) step("abcdef", 1'b1, 0);
    key_valid = 1'b0;
    key_last  = 1'b0;
    chk("bp_progress", exp_n > 60, 1'b1);

    // Stop coincident with the fire of nonce 42
    do_reset();
    load_key("abcdef");
    for (int c = 0; c < 100 && exp_n < 43; c++) step("abcdef", 1'b0, 42);
    chk("stop_reach", exp_n, 43);
    @(negedge clk);
    stop = 1'b0;
    chk("stop_valid_next", a_valid, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stop_valid_stays", a_valid, 1'b0);
    end

    // Overflow on the 2-digit instance
    do_reset();
    sel_b = 1'b1;
    load_key("abcdef");
    for (int c = 0; c < 200 && exp_n < 100; c++) step("abcdef", 1'b0, 0);
    chk("ovf_reach", exp_n, 100);
    @(negedge clk);
    chk("ovf_set", b_ovf, 1'b1);
    chk("ovf_valid_low", b_valid, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("ovf_sticky", b_ovf, 1'b1);
      chk("ovf_valid_stays", b_valid, 1'b0);
    end
    sel_b = 1'b0;

    // Reset mid-run at nonce 500, reload a short key
    do_reset();
    load_key("abcdef");
    for (int c = 0; c < 700 && exp_n < 500; c++) step("abcdef", 1'b0, 0);
    chk("midrun_reach", exp_n, 500);
    do_reset();
    load_key("xyz");
    step("xyz", 1'b0, 0);
    chk("xyz_valid", prev_valid, 1'b1);
    chk("xyz_len", prev_data[31:0], 32'h78797a31);
    chk("xyz_ovf", a_ovf, 1'b0);
    for (int c = 0; c < 3; c++) step("xyz", 1'b0, 0);

    // Key saturation: bytes past 16 dropped, key_last still honoured
    do_reset();
    load_key("ABCDEFGHIJKLMNOPQR");
    step("ABCDEFGHIJKLMNOPQR", 1'b0, 0);
    chk("sat_len", prev_valid ? a_len : 6'd63, 6'd17);
    for (int c = 0; c < 12; c++) step("ABCDEFGHIJKLMNOPQR", 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
